// File: rtl/vec_alu_pipe.sv
// rtl/vec_alu_pipe.sv - registered multi-lane vector ALU stage with masked reduction-sum
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   stg_en          stage enable; low freezes every register and blocks both handshakes
//   in_valid/in_ready, in1, in2, alu_control, vmask
//                   operand bundle; lane i of in1/in2 sits at [i*XLEN +: XLEN]
//   out_valid/out_ready, alu_result, zero_flag, all_zero, illegal_op
//                   registered result bundle, held stable until consumed
module vec_alu_pipe #(
    parameter int XLEN  = 32,
    parameter int LANES = 4,
    parameter int SHW   = $clog2(XLEN)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stg_en,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [LANES*XLEN-1:0] in1,
    input  logic [LANES*XLEN-1:0] in2,
    input  logic [3:0]            alu_control,
    input  logic [LANES-1:0]      vmask,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [LANES*XLEN-1:0] alu_result,
    output logic [LANES-1:0]      zero_flag,
    output logic                  all_zero,
    output logic                  illegal_op
);

    localparam logic [3:0] OP_AND    = 4'd0;
    localparam logic [3:0] OP_OR     = 4'd1;
    localparam logic [3:0] OP_ADD    = 4'd2;
    localparam logic [3:0] OP_SUB    = 4'd3;
    localparam logic [3:0] OP_SEQ    = 4'd4;
    localparam logic [3:0] OP_SLL    = 4'd5;
    localparam logic [3:0] OP_SRL    = 4'd6;
    localparam logic [3:0] OP_XOR    = 4'd7;
    localparam logic [3:0] OP_REDSUM = 4'd8;

    localparam int IDXW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(LANES - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_REDUCE = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    // Operands captured for the reduction, since the source may move on after accept.
    logic [LANES*XLEN-1:0] red_data;
    logic [LANES-1:0]      red_mask;
    logic [XLEN-1:0]       acc;
    logic [IDXW-1:0]       idx;
    logic [XLEN-1:0]       red_lane;

    logic accept;
    logic out_fire;
    logic op_illegal;
    logic op_redsum;

    logic [LANES*XLEN-1:0] ew_result;
    logic [LANES-1:0]      ew_zero;
    logic                  ew_all_zero;
    logic [XLEN-1:0]       lane_a;
    logic [XLEN-1:0]       lane_b;
    logic [XLEN-1:0]       lane_r;

    assign in_ready   = stg_en & ~rst & (state == S_IDLE) & (~out_valid | out_ready);
    assign accept     = in_valid & in_ready;
    assign out_fire   = stg_en & out_valid & out_ready;
    assign op_illegal = (alu_control > OP_REDSUM);
    assign op_redsum  = (alu_control == OP_REDSUM);
    assign red_lane   = red_data[idx*XLEN +: XLEN];

    // Element-wise datapath, evaluated straight from the input bus so the
    // result registers can load on the accept edge itself.
    always_comb begin
        ew_result   = '0;
        ew_zero     = '0;
        ew_all_zero = ~op_illegal;
        lane_a      = '0;
        lane_b      = '0;
        lane_r      = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_a = in1[i*XLEN +: XLEN];
            lane_b = in2[i*XLEN +: XLEN];
            case (alu_control)
                OP_AND:  lane_r = lane_a & lane_b;
                OP_OR:   lane_r = lane_a | lane_b;
                OP_ADD:  lane_r = lane_a + lane_b;
                OP_SUB:  lane_r = lane_a - lane_b;
                OP_SEQ:  lane_r = {{(XLEN-1){1'b0}}, (lane_a == lane_b)};
                OP_SLL:  lane_r = lane_a << lane_b[SHW-1:0];
                OP_SRL:  lane_r = lane_a >> lane_b[SHW-1:0];
                OP_XOR:  lane_r = lane_a ^ lane_b;
                default: lane_r = '0;
            endcase
            if (op_illegal) begin
                ew_result[i*XLEN +: XLEN] = '0;
            end else if (vmask[i]) begin
                ew_result[i*XLEN +: XLEN] = lane_r;
                ew_zero[i]                = (lane_r == '0);
                ew_all_zero               = ew_all_zero & (lane_r == '0);
            end else begin
                // Inactive lanes pass operand A through and do not vote in all_zero.
                ew_result[i*XLEN +: XLEN] = lane_a;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else if (stg_en) begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (accept && op_redsum) begin
                    state_next = S_REDUCE;
                end
            end
            S_REDUCE: begin
                if (idx == LAST_IDX) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            red_data   <= '0;
            red_mask   <= '0;
            acc        <= '0;
            idx        <= '0;
            out_valid  <= 1'b0;
            alu_result <= '0;
            zero_flag  <= '0;
            all_zero   <= 1'b0;
            illegal_op <= 1'b0;
        end else if (stg_en) begin
            if (out_fire) begin
                out_valid <= 1'b0;
            end
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        if (op_redsum) begin
                            red_data <= in1;
                            red_mask <= vmask;
                            acc      <= in2[XLEN-1:0];
                            idx      <= '0;
                        end else begin
                            alu_result <= ew_result;
                            zero_flag  <= ew_zero;
                            all_zero   <= ew_all_zero;
                            illegal_op <= op_illegal;
                            out_valid  <= 1'b1;
                        end
                    end
                end
                S_REDUCE: begin
                    if (red_mask[idx]) begin
                        acc <= acc + red_lane;
                    end
                    idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
                end
                S_DONE: begin
                    // Result lane 0 carries the sum; every other lane and flag reads zero.
                    alu_result             <= '0;
                    alu_result[XLEN-1:0]   <= acc;
                    zero_flag              <= '0;
                    zero_flag[0]           <= (acc == '0);
                    all_zero               <= (acc == '0);
                    illegal_op             <= 1'b0;
                    out_valid              <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
